// File: rtl/switch_nport.sv
// switch_nport: address-routed 1-to-N packet switch. Each output has its own
// show-ahead FIFO, so a stalled consumer only backs up traffic bound for its
// own port. The destination comes from the top address bits, and the full
// address is forwarded with the payload.
module switch_nport #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             vld,
    output logic                             rdy,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic [DATA_WIDTH-1:0]            data,
    output logic [NUM_PORTS-1:0]             vld_out,
    input  logic [NUM_PORTS-1:0]             rdy_out,
    output logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_out,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  data_out
);

    localparam int PORT_BITS = $clog2(NUM_PORTS);
    localparam int PTR_BITS  = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W   = ADDR_WIDTH + DATA_WIDTH;

    logic [PORT_BITS-1:0] w_dest;
    logic [NUM_PORTS-1:0] w_full;
    logic [NUM_PORTS-1:0] w_empty;
    logic [NUM_PORTS-1:0] w_push;
    logic [NUM_PORTS-1:0] w_pop;

    assign w_dest = addr[ADDR_WIDTH-1 -: PORT_BITS];

    // Acceptance depends only on the destination FIFO's fullness. A pop in the
    // same cycle does not make room, which keeps rdy off the consumer ready paths.
    assign rdy = rstn && !w_full[w_dest];

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
            logic [PTR_BITS:0]   r_wr_ptr;
            logic [PTR_BITS:0]   r_rd_ptr;
            logic [ENTRY_W-1:0]  w_head;

            // The pointers carry one extra wrap bit. Equal low bits with
            // different wrap bits means the FIFO is full.
            assign w_full[gi]  = (r_wr_ptr[PTR_BITS-1:0] == r_rd_ptr[PTR_BITS-1:0]) &&
                                 (r_wr_ptr[PTR_BITS] != r_rd_ptr[PTR_BITS]);
            assign w_empty[gi] = (r_wr_ptr == r_rd_ptr);
            assign w_push[gi]  = vld && rdy && (w_dest == PORT_BITS'(gi));
            assign w_pop[gi]   = vld_out[gi] && rdy_out[gi];

            // Pointer update. Reset wins over any push or pop in the same cycle.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_push[gi]) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop[gi]) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                end
            end

            // Storage write. The contents are never reset, because the empty
            // flag masks stale entries.
            always_ff @(posedge clk) begin
                if (w_push[gi]) begin
                    r_mem[r_wr_ptr[PTR_BITS-1:0]] <= {addr, data};
                end
            end

            // The head is read combinationally, so a beat pushed at one edge
            // is on the port in the following cycle.
            assign w_head      = r_mem[r_rd_ptr[PTR_BITS-1:0]];
            assign vld_out[gi] = rstn && !w_empty[gi];
            assign addr_out[gi*ADDR_WIDTH +: ADDR_WIDTH] =
                vld_out[gi] ? w_head[ENTRY_W-1 -: ADDR_WIDTH] : '0;
            assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] =
                vld_out[gi] ? w_head[DATA_WIDTH-1:0] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_switch_nport.sv
// tb_switch_nport: directed stimulus for the 4-port switch. Each accepted beat
// pushes its expected response into a per-port scoreboard queue. A separate
// monitor pops from the queue on every output transfer and checks the beat.
module tb_switch_nport;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        vld = 1'b0;
    logic        rdy;
    logic [7:0]  addr = 8'h00;
    logic [15:0] data = 16'h0000;
    logic [3:0]  vld_out;
    logic [3:0]  rdy_out = 4'h0;
    logic [31:0] addr_out;
    logic [63:0] data_out;

    switch_nport #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(16),
        .NUM_PORTS (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .vld     (vld),
        .rdy     (rdy),
        .addr    (addr),
        .data    (data),
        .vld_out (vld_out),
        .rdy_out (rdy_out),
        .addr_out(addr_out),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sb[4][$];
    bit   chk_lat = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: on each output transfer, check the beat against the scoreboard.
    // While a port is idle, its output slices must read as zero.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (vld_out[k] && rdy_out[k]) begin
                if (sb[k].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat port%0d: got addr=%02h data=%04h expected none",
                             k, addr_out[k*8 +: 8], data_out[k*16 +: 16]);
                end else begin
                    e = sb[k].pop_front();
                    $display("port%0d out addr=%02h data=%04h cyc=%0d",
                             k, addr_out[k*8 +: 8], data_out[k*16 +: 16], cyc);
                    check($sformatf("addr_port%0d", k), 64'(addr_out[k*8 +: 8]), 64'(e.a));
                    check($sformatf("data_port%0d", k), 64'(data_out[k*16 +: 16]), 64'(e.d));
                    if (e.lat) begin
                        check($sformatf("latency_port%0d", k), 64'(cyc), 64'(e.cyc + 1));
                    end
                end
            end else if (!vld_out[k]) begin
                check($sformatf("idle_addr_port%0d", k), 64'(addr_out[k*8 +: 8]), 64'd0);
                check($sformatf("idle_data_port%0d", k), 64'(data_out[k*16 +: 16]), 64'd0);
            end
        end
    end

    // Present one beat and hold it until it is accepted, then record the
    // expected beat on the port selected by the top two address bits.
    task automatic send(input logic [7:0] a, input logic [15:0] d, input bit must_rdy);
        int n = 0;
        vld  = 1'b1;
        addr = a;
        data = d;
        forever begin
            @(negedge clk);
            if (must_rdy && n == 0) check("rdy_immediate", 64'(rdy), 64'd1);
            if (rdy) break;
            n++;
            if (n > 20) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got rdy=0 for addr %02h, required rdy=1 within 20 cycles", a);
                vld = 1'b0;
                return;
            end
        end
        sb[a[7:6]].push_back(exp_t'{a, d, cyc, chk_lat});
        $display("in  addr=%02h data=%04h cyc=%0d", a, d, cyc);
        @(posedge clk);
        #1;
        vld = 1'b0;
    endtask

    // Port p is full while its consumer is stalled. Release the consumer with
    // a new beat for the same port already presented. There is no same-cycle
    // bypass, so the beat is refused in the first cycle and accepted in the
    // next. Over five cycles the port must drain continuously.
    task automatic release_full(input int p, input logic [7:0] a, input logic [15:0] d);
        rdy_out[p] = 1'b1;
        vld  = 1'b1;
        addr = a;
        data = d;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("drain_vld", 64'(vld_out[p]), 64'd1);
            if (i == 0) check("nobypass_rdy", 64'(rdy), 64'd0);
            if (i == 1) begin
                check("release_rdy", 64'(rdy), 64'd1);
                sb[p].push_back(exp_t'{a, d, cyc, 1'b0});
                $display("in  addr=%02h data=%04h cyc=%0d", a, d, cyc);
            end
            @(posedge clk);
            #1;
            if (i == 1) vld = 1'b0;
        end
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vld_out", 64'(vld_out), 64'd0);
        check("rst_rdy", 64'(rdy), 64'd0);
        check("rst_addr_out", 64'(addr_out), 64'd0);
        check("rst_data_out", data_out, 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_rdy", 64'(rdy), 64'd1);
        check("post_rst_vld_out", 64'(vld_out), 64'd0);
        @(posedge clk);
        #1;

        // Routing: one beat to each port, visible in the next cycle.
        rdy_out = 4'hF;
        chk_lat = 1'b1;
        send(8'h05, 16'd1, 1'b1);
        send(8'h47, 16'd2, 1'b1);
        send(8'h9A, 16'd3, 1'b1);
        send(8'hFF, 16'd4, 1'b1);
        chk_lat = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: port2 is stalled and fills after four beats. Traffic
        // for another port still gets through.
        rdy_out = 4'b1011;
        for (int i = 0; i < 4; i++) send(8'h80 + 8'(i), 16'h0100 + 16'(i), 1'b1);
        vld  = 1'b1;
        addr = 8'h84;
        data = 16'h0104;
        @(negedge clk);
        check("full_rdy", 64'(rdy), 64'd0);
        @(posedge clk);
        #1;
        send(8'h10, 16'h0110, 1'b1);

        // Drain order: port2 emits 0x80..0x83, then accepts and emits 0x84.
        release_full(2, 8'h84, 16'h0104);
        repeat (3) @(posedge clk);
        #1;

        // Full with no bypass on port1.
        rdy_out[1] = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h41 + 8'(i), 16'h0200 + 16'(i), 1'b1);
        release_full(1, 8'h40, 16'h0240);
        repeat (3) @(posedge clk);
        #1;

        // Steady stream of random beats back to back.
        rdy_out = 4'hF;
        chk_lat = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send(8'($urandom_range(0, 255)), 16'($urandom), 1'b1);
        end
        chk_lat = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-operation with three beats buffered on port3 and another
        // beat presented.
        rdy_out = 4'b0111;
        send(8'hC1, 16'h0301, 1'b1);
        send(8'hC2, 16'h0302, 1'b1);
        send(8'hC3, 16'h0303, 1'b1);
        rstn = 1'b0;
        sb[3].delete();
        vld  = 1'b1;
        addr = 8'hC4;
        data = 16'h0304;
        @(negedge clk);
        check("midrst_vld_out", 64'(vld_out), 64'd0);
        check("midrst_rdy", 64'(rdy), 64'd0);
        check("midrst_addr_out", 64'(addr_out), 64'd0);
        check("midrst_data_out", data_out, 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        vld  = 1'b0;
        @(negedge clk);
        check("after_rst_vld_out", 64'(vld_out), 64'd0);
        @(posedge clk);
        #1;
        rdy_out = 4'hF;
        chk_lat = 1'b1;
        send(8'hC9, 16'h0999, 1'b1);
        chk_lat = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // All expected beats must have been delivered.
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sb_left_port%0d", k), 64'(sb[k].size()), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
